// File: rtl/fibo_pkg.sv
// Shared types and default sizes for the parametrised Fibonacci generator.
package fibo_pkg;

  localparam int FIBO_WIDTH = 8;
  localparam int FIBO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fibo_state_e;

endpackage

// File: rtl/fibo_gen_param_if.sv
// Command and term-stream signals between the generator, its control master
// and the downstream consumer.
interface fibo_gen_param_if
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int CNT_W = FIBO_CNT_W
);
  logic             start;
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
  logic [CNT_W-1:0] num_terms;
  logic             term_ready;
  logic [WIDTH-1:0] fibo_term;
  logic             term_valid;
  logic [CNT_W-1:0] term_idx;
  logic             term_ovf;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, seed0, seed1, num_terms, term_ready,
    input  fibo_term, term_valid, term_idx, term_ovf, overflow, busy, done
  );

  modport slave (
    input  start, seed0, seed1, num_terms, term_ready,
    output fibo_term, term_valid, term_idx, term_ovf, overflow, busy, done
  );
endinterface

// File: rtl/rcadder_nb.sv
// WIDTH-bit ripple-carry adder; each stage takes its carry from the previous
// generate block so the chain stays a plain bit-serial ripple.
module rcadder_nb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic w_ci;
      logic w_co;
      if (gi == 0) begin : g_lsb
        assign w_ci = 1'b0;
      end else begin : g_mid
        assign w_ci = g_fa[gi-1].w_co;
      end
      assign sum[gi] = a[gi] ^ b[gi] ^ w_ci;
      assign w_co    = (a[gi] & b[gi]) | (w_ci & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = g_fa[WIDTH-1].w_co;

endmodule

// File: rtl/fibo_gen_param.sv
// Fibonacci sequence generator with start/done command and valid/ready term output.
// Build option FIBO_SAT_EN: saturate a carrying term to all-ones and end the sequence on it.
module fibo_gen_param
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int CNT_W = FIBO_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  fibo_gen_param_if.slave  bus
);

  fibo_state_e      r_state;
  fibo_state_e      w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_ovf;
  logic             r_b_ovf;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_num;
  logic             r_overflow;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_b_next;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  rcadder_nb #(.WIDTH(WIDTH)) u_add (
    .a    (r_b),
    .b    (r_a),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_accept = (r_state == RUN) && bus.term_ready;
`ifdef FIBO_SAT_EN
    w_b_next = w_cout ? {WIDTH{1'b1}} : w_sum;
    // A saturated term is final no matter how many terms were requested.
    w_last   = (r_idx == r_num - CNT_W'(1)) || r_a_ovf;
`else
    w_b_next = w_sum;
    w_last   = (r_idx == r_num - CNT_W'(1));
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.num_terms == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_accept && w_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_a_ovf    <= 1'b0;
      r_b_ovf    <= 1'b0;
      r_idx      <= '0;
      r_num      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.start) begin
        r_a        <= bus.seed0;
        r_b        <= bus.seed1;
        r_a_ovf    <= 1'b0;
        r_b_ovf    <= 1'b0;
        r_idx      <= '0;
        r_num      <= bus.num_terms;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        r_a        <= r_b;
        r_a_ovf    <= r_b_ovf;
        r_b        <= w_b_next;
        r_b_ovf    <= w_cout;
        r_idx      <= r_idx + CNT_W'(1);
        r_overflow <= r_overflow | r_a_ovf;
      end
    end
  end

  assign bus.term_valid = (r_state == RUN);
  assign bus.fibo_term  = (r_state == RUN) ? r_a : '0;
  assign bus.term_ovf   = (r_state == RUN) & r_a_ovf;
  assign bus.term_idx   = r_idx;
  assign bus.overflow   = r_overflow;
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);

endmodule

// File: tb/tb_fibo_gen_param.sv
// Self-checking bench for fibo_gen_param: table vectors, corner sequences and
// randomized runs checked against a list-of-terms reference model.
module tb_fibo_gen_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fibo_gen_param_if #(.WIDTH(8), .CNT_W(8)) bus ();

  fibo_gen_param #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef FIBO_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  int m_val[$];
  bit m_ovf[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected terms: each is the plain sum of the two before it, reduced mod 256;
  // a sum of 256 or more marks the term as overflowed.
  task automatic build_model(input int s0, input int s1, input int n);
    int sum;
    bit ov;
    m_val.delete();
    m_ovf.delete();
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        sum = s0; ov = 1'b0;
      end else if (k == 1) begin
        sum = s1; ov = 1'b0;
      end else begin
        sum = m_val[k-1] + m_val[k-2];
        ov  = (sum > 255);
      end
      m_val.push_back((SAT && ov) ? 255 : sum % 256);
      m_ovf.push_back(ov);
      if (SAT && ov) break;
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: hold ready low 3 cycles at T5
  task automatic run_seq(input int s0, input int s1, input int n, input int mode,
                         input bit poke_start, output int emitted, output int last_val);
    int  acc;
    int  len;
    int  stall;
    bit  fin;
    bit  exp_done;
    bit  any_ovf;
    bit  rdy;
    build_model(s0, s1, n);
    len = m_val.size();
    acc = 0; stall = 0; fin = 1'b0; exp_done = 1'b0; any_ovf = 1'b0; last_val = -1;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    bus.start     = 1'b1;
    bus.seed0     = 8'(s0);
    bus.seed1     = 8'(s1);
    bus.num_terms = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.seed0 = 8'hAA;
    bus.seed1 = 8'h55;
    bus.num_terms = 8'd3;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (exp_done || len == 0) begin
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_valid", bus.term_valid, 0);
        bus.term_ready = 1'b0;
        fin = 1'b1;
      end else begin
        chk("valid", bus.term_valid, 1);
        chk("term_idx", bus.term_idx, acc);
        chk("term", bus.fibo_term, m_val[acc]);
        chk("term_ovf", bus.term_ovf, m_ovf[acc]);
        chk("overflow_run", bus.overflow, any_ovf);
        chk("no_done", bus.done, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 99) < 70);
          default: begin
            if (acc == 5 && stall < 3) begin
              rdy = 1'b0; stall++;
            end else begin
              rdy = 1'b1;
            end
          end
        endcase
        bus.term_ready = rdy;
        if (poke_start && acc == 2) begin
          bus.start = 1'b1; bus.seed0 = 8'd77; bus.seed1 = 8'd88; bus.num_terms = 8'd1;
        end else begin
          bus.start = 1'b0;
        end
        if (rdy) begin
          any_ovf  = any_ovf | m_ovf[acc];
          last_val = int'(bus.fibo_term);
          acc++;
          if (acc == len) exp_done = 1'b1;
        end
        @(negedge clk);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    bus.start = 1'b0;
    chk("overflow_end", bus.overflow, any_ovf);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    emitted = acc;
    $display("seq seed0=%0d seed1=%0d num=%0d mode=%0d terms=%0d last=%0d ovf=%0d",
             s0, s1, n, mode, acc, last_val, any_ovf);
  endtask

  typedef struct {
    int s0;
    int s1;
    int n;
    int mode;
    int exp_len;
    int exp_last;
  } vec_t;

  vec_t tbl[5];
  int   em;
  int   lv;

  initial begin
    tbl[0] = '{s0: 0, s1: 1, n: 10, mode: 0, exp_len: 10, exp_last: 34};
    tbl[1] = '{s0: 2, s1: 3, n: 4,  mode: 1, exp_len: 4,  exp_last: 8};
    tbl[2] = '{s0: 5, s1: 5, n: 3,  mode: 1, exp_len: 3,  exp_last: 10};
    tbl[3] = '{s0: 1, s1: 1, n: 1,  mode: 0, exp_len: 1,  exp_last: 1};
    tbl[4] = '{s0: 9, s1: 4, n: 0,  mode: 0, exp_len: 0,  exp_last: -1};

    reset = 1'b1;
    bus.start = 1'b0; bus.seed0 = '0; bus.seed1 = '0; bus.num_terms = '0; bus.term_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_term", bus.fibo_term, 0);
    chk("rst_valid", bus.term_valid, 0);
    chk("rst_idx", bus.term_idx, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_seq(tbl[i].s0, tbl[i].s1, tbl[i].n, tbl[i].mode, 1'b0, em, lv);
      chk("tbl_len", em, tbl[i].exp_len);
      chk("tbl_last", lv, tbl[i].exp_last);
    end

    // Carry past 255 from T14 onward: wraps by default, saturates and stops otherwise.
    run_seq(0, 1, 16, 0, 1'b0, em, lv);
    chk("wrap_len", em, SAT ? 15 : 16);
    chk("wrap_last", lv, SAT ? 255 : 98);
    chk("wrap_sticky", bus.overflow, 1);

    run_seq(0, 1, 10, 2, 1'b0, em, lv);
    chk("bp_len", em, 10);

    run_seq(0, 1, 8, 0, 1'b1, em, lv);
    chk("poke_len", em, 8);
    chk("poke_last", lv, 13);

    // Asynchronous reset in the middle of a sequence.
    @(negedge clk);
    bus.start = 1'b1; bus.seed0 = 8'd0; bus.seed1 = 8'd1; bus.num_terms = 8'd10;
    bus.term_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && bus.term_idx != 8'd4; i++) @(negedge clk);
    chk("reach_t4", bus.term_idx, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_term", bus.fibo_term, 0);
    chk("arst_valid", bus.term_valid, 0);
    chk("arst_idx", bus.term_idx, 0);
    chk("arst_ovf", bus.term_ovf, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.term_ready = 1'b0;
    run_seq(2, 3, 4, 0, 1'b0, em, lv);
    chk("post_rst_len", em, 4);
    chk("post_rst_last", lv, 8);

    for (int r = 0; r < 20; r++) begin
      run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 25)), 1, 1'b0, em, lv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
